apb_bus_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the MCU APB bus. Requester 0 is
//  the RV32I core data port; requester 1 is a second bus master (DMA/debug).
//  - Grants one requester at a time, round-robin.
//  - Runs the APB SETUP/ACCESS sequence on the shared bus.
//  - Returns read data and a completion pulse to the granted requester.
//  - Aborts with an error if a peripheral never asserts PREADY.

---
 rtl/apb_bus_arbiter_if.sv | 42 ++++
 rtl/apb_bus_arbiter.sv | 96 +++++++++
 tb/tb_apb_bus_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_bus_arbiter_if.sv
// apb_bus_arbiter_if: requester-side and APB-side signals of the two-master APB arbiter.
// The master modport is the arbiter's view; slave is the view of the requesters plus the decoder/mux.
interface apb_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m1_req;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m0_write;
    logic          m1_write;
    logic [DW-1:0] m0_rdata;
    logic [DW-1:0] m1_rdata;
    logic          m0_ready;
    logic          m1_ready;
    logic          m0_err;
    logic          m1_err;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    modport master (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_write, m1_write,
        input  PRDATA, PREADY,
        output m0_rdata, m1_rdata, m0_ready, m1_ready, m0_err, m1_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_write, m1_write,
        output PRDATA, PREADY,
        input  m0_rdata, m1_rdata, m0_ready, m1_ready, m0_err, m1_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin two-requester arbiter driving the APB SETUP/ACCESS sequence.
// A stalled ACCESS phase is aborted with an error after TIMEOUT_CYC cycles (0 disables it).
module apb_bus_arbiter #(
    parameter int TIMEOUT_CYC = 16,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_bus_arbiter_if.master   bus
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic          r_gnt;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_paddr;
    logic [DW-1:0] r_pwdata;
    logic          r_pwrite;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          w_any;
    logic          w_gnt;
    logic          w_timeout;
    logic          w_cap;
    logic [DW-1:0] w_rd_val;

    assign w_any     = bus.m0_req | bus.m1_req;
    assign w_gnt     = (bus.m0_req & bus.m1_req) ? ~r_last : bus.m1_req;
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_cap     = (r_state == ACCESS) && !r_pwrite && (bus.PREADY || w_timeout);
    // A timed-out read returns zero rather than whatever sits on PRDATA.
    assign w_rd_val  = bus.PREADY ? bus.PRDATA : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (bus.PREADY || w_timeout) ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.PSEL     = (r_state == SETUP) || (r_state == ACCESS);
        bus.PENABLE  = r_state == ACCESS;
        bus.m0_ready = (r_state == DONE) && !r_gnt;
        bus.m1_ready = (r_state == DONE) && r_gnt;
        bus.m0_err   = bus.m0_ready && r_err;
        bus.m1_err   = bus.m1_ready && r_err;
        bus.PADDR    = r_paddr;
        bus.PWDATA   = r_pwdata;
        bus.PWRITE   = r_pwrite;
        bus.m0_rdata = r_rdata0;
        bus.m1_rdata = r_rdata1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt    <= w_gnt;
                r_paddr  <= w_gnt ? bus.m1_addr : bus.m0_addr;
                r_pwdata <= w_gnt ? bus.m1_wdata : bus.m0_wdata;
                r_pwrite <= w_gnt ? bus.m1_write : bus.m0_write;
                if (bus.m0_req && bus.m1_req) r_last <= w_gnt;
            end
            if (r_state == SETUP) r_cnt <= '0;
            if (r_state == ACCESS && !bus.PREADY && !w_timeout) r_cnt <= r_cnt + 1'b1;
            if (r_state == ACCESS && !bus.PREADY && w_timeout) r_err <= 1'b1;
            if (r_state == DONE) r_err <= 1'b0;
            if (w_cap && !r_gnt) r_rdata0 <= w_rd_val;
            if (w_cap && r_gnt) r_rdata1 <= w_rd_val;
        end
    end
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: directed checks of grant order, APB timing, timeout and reset behaviour.
module tb_apb_bus_arbiter;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

    apb_bus_arbiter #(.TIMEOUT_CYC(16), .AW(32), .DW(32)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.m0_req = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_write = 0;
        bus.m1_req = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_write = 0;
        bus.PRDATA = 0; bus.PREADY = 0;
        #1;
        chk("rst_psel", {31'd0, bus.PSEL}, 0);
        chk("rst_penable", {31'd0, bus.PENABLE}, 0);
        chk("rst_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
        chk("rst_paddr", bus.PADDR, 0);
        tick; tick;
        PRESET = 0;
        // single read, zero wait states
        bus.m0_req = 1; bus.m0_addr = 32'h1000_2000; bus.m0_write = 0;
        tick;
        chk("t1_setup_psel", {31'd0, bus.PSEL}, 1);
        chk("t1_setup_pen", {31'd0, bus.PENABLE}, 0);
        chk("t1_setup_paddr", bus.PADDR, 32'h1000_2000);
        tick;
        chk("t1_access_pen", {31'd0, bus.PENABLE}, 1);
        bus.PREADY = 1; bus.PRDATA = 32'hA5;
        tick;
        chk("t1_ready", {31'd0, bus.m0_ready}, 1);
        chk("t1_rdata", bus.m0_rdata, 32'hA5);
        chk("t1_err", {31'd0, bus.m0_err}, 0);
        chk("t1_done_psel", {31'd0, bus.PSEL}, 0);
        bus.m0_req = 0; bus.PREADY = 0; bus.PRDATA = 32'hDEAD;
        tick;
        chk("t1_idle_ready", {31'd0, bus.m0_ready}, 0);
        chk("t1_rdata_held", bus.m0_rdata, 32'hA5);
        // write with three wait states
        bus.m1_req = 1; bus.m1_addr = 32'h1000_1000; bus.m1_wdata = 32'h3C; bus.m1_write = 1;
        tick;
        chk("t2_setup_pwrite", {31'd0, bus.PWRITE}, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t2_access_pen", {31'd0, bus.PENABLE}, 1);
            chk("t2_access_paddr", bus.PADDR, 32'h1000_1000);
            chk("t2_access_pwdata", bus.PWDATA, 32'h3C);
            chk("t2_access_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
            if (i == 3) bus.PREADY = 1;
        end
        tick;
        chk("t2_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 2'b10);
        chk("t2_err", {31'd0, bus.m1_err}, 0);
        chk("t2_m1_rdata_unchanged", bus.m1_rdata, 0);
        bus.m1_req = 0; bus.PREADY = 0;
        tick;
        chk("t2_idle_ready", {31'd0, bus.m1_ready}, 0);
        // both requesting continuously: grants alternate starting with m0
        bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_write = 0;
        bus.m1_req = 1; bus.m1_addr = 32'h44; bus.m1_write = 0;
        bus.PREADY = 1; bus.PRDATA = 32'h11;
        for (int g = 0; g < 4; g++) begin
            tick;
            chk("t3_paddr", bus.PADDR, (g % 2 == 0) ? 32'h40 : 32'h44);
            tick;
            tick;
            chk("t3_ready", {30'd0, bus.m1_ready, bus.m0_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
            tick;
            chk("t3_idle_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
        end
        bus.m0_req = 0; bus.m1_req = 0; bus.PREADY = 0; bus.PRDATA = 32'hBEEF;
        chk("t3_m1_rdata", bus.m1_rdata, 32'h11);
        // timeout: PREADY never comes
        bus.m0_req = 1; bus.m0_addr = 32'h50; bus.m0_write = 0;
        tick;
        for (int i = 0; i < 16; i++) begin
            tick;
            chk("t4_access_pen", {31'd0, bus.PENABLE}, 1);
        end
        tick;
        chk("t4_ready", {31'd0, bus.m0_ready}, 1);
        chk("t4_err", {31'd0, bus.m0_err}, 1);
        chk("t4_rdata_zero", bus.m0_rdata, 0);
        bus.m0_req = 0;
        tick;
        chk("t4_idle_err", {31'd0, bus.m0_err}, 0);
        bus.m0_req = 1; bus.PREADY = 1; bus.PRDATA = 32'h5A;
        tick; tick; tick;
        chk("t4_next_ready", {31'd0, bus.m0_ready}, 1);
        chk("t4_next_err", {31'd0, bus.m0_err}, 0);
        chk("t4_next_rdata", bus.m0_rdata, 32'h5A);
        bus.m0_req = 0; bus.PREADY = 0;
        tick;
        // m1 arrives while m0 is in ACCESS
        bus.m0_req = 1; bus.m0_addr = 32'h70; bus.m0_write = 0; bus.PRDATA = 32'h99;
        tick; tick;
        bus.m1_req = 1; bus.m1_addr = 32'h74; bus.m1_wdata = 32'h12; bus.m1_write = 1;
        tick;
        chk("t5_m0_still_owns", bus.PADDR, 32'h70);
        bus.PREADY = 1;
        tick;
        chk("t5_m0_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 1);
        chk("t5_done_psel", {31'd0, bus.PSEL}, 0);
        bus.m0_req = 0; bus.PREADY = 0;
        tick;
        chk("t5_idle_psel", {31'd0, bus.PSEL}, 0);
        tick;
        chk("t5_m1_paddr", bus.PADDR, 32'h74);
        chk("t5_m1_pwrite", {31'd0, bus.PWRITE}, 1);
        bus.PREADY = 1;
        tick; tick;
        chk("t5_m1_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 2);
        chk("t5_m1_rdata_kept", bus.m1_rdata, 32'h11);
        bus.m1_req = 0; bus.PREADY = 0;
        tick;
        // reset during ACCESS, then tie goes to m0 again
        bus.m0_req = 1; bus.m0_addr = 32'h60; bus.m0_write = 0;
        bus.m1_req = 1; bus.m1_addr = 32'h64; bus.m1_write = 0;
        tick;
        chk("t6_first_paddr", bus.PADDR, 32'h60);
        tick;
        chk("t6_access_pen", {31'd0, bus.PENABLE}, 1);
        PRESET = 1;
        #1;
        chk("t6_rst_psel", {31'd0, bus.PSEL}, 0);
        chk("t6_rst_pen", {31'd0, bus.PENABLE}, 0);
        chk("t6_rst_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 0);
        chk("t6_rst_rdata", bus.m0_rdata, 0);
        #2;
        PRESET = 0;
        tick;
        chk("t6_regrant_paddr", bus.PADDR, 32'h60);
        chk("t6_regrant_psel", {31'd0, bus.PSEL}, 1);
        bus.PREADY = 1; bus.PRDATA = 32'h77;
        tick; tick;
        chk("t6_ready", {30'd0, bus.m1_ready, bus.m0_ready}, 1);
        chk("t6_rdata", bus.m0_rdata, 32'h77);
        bus.m0_req = 0; bus.m1_req = 0; bus.PREADY = 0;
        tick;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
